// File: rtl/clock_ctrl_pkg.sv
// clock_ctrl_pkg
//   Shared definitions for the BasicCPU clock sequencer: the sequencer
//   state encoding, default divider sizing and the smallest legal
//   half-period.
package clock_ctrl_pkg;

  // Sequencer states: parked low, free-running, or issuing one period.
  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_e;

  // Default phase-counter width and half-period in board clock cycles.
  localparam int DEF_CNT_W       = 24;
  localparam int DEF_HALF_PERIOD = 130000;

  // A half-period of zero cannot be counted; it is raised to this value.
  localparam int MIN_HALF = 1;

endpackage

// File: rtl/clock_phase_div.sv
// clock_phase_div
//   Phase counter and toggle for the CPU clock. It counts board clock
//   cycles and flips the CPU clock level when the count reaches the
//   programmed half-period. A tick is registered alongside every low-to-high
//   flip. The half-period is held in a register here; a written value of
//   zero is raised to the minimum.
//
// Ports
//   clk        in   board clock
//   rst        in   synchronous reset, active-high
//   en         in   count and toggle this cycle (sequencer is RUN or STEP)
//   restart    in   force count to 0 and the clock low
//   hold_low   in   a stop is requested: never start a new high phase
//   half_we    in   write strobe for the half-period
//   half_in    in   new half-period value
//   cpu_clk    out  divided clock, registered
//   tick       out  one-cycle pulse registered with each rising edge
//   fall       out  the current edge turns the clock from high to low
module clock_phase_div
  import clock_ctrl_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int HALF_PERIOD = DEF_HALF_PERIOD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             restart,
  input  logic             hold_low,
  input  logic             half_we,
  input  logic [CNT_W-1:0] half_in,
  output logic             cpu_clk,
  output logic             tick,
  output logic             fall
);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] half_r;
  logic             cpu_clk_r;
  logic             tick_r;
  logic             terminal_s;

  // Raise a zero half-period to the minimum countable length.
  function automatic logic [CNT_W-1:0] clamp_half(input logic [CNT_W-1:0] value);
    if (value == {CNT_W{1'b0}}) begin
      clamp_half = CNT_W'(MIN_HALF);
    end else begin
      clamp_half = value;
    end
  endfunction

  assign terminal_s = (cnt_r == (half_r - CNT_W'(1)));

  // A falling toggle happens only on a counted terminal edge; a
  // coincident half-period write suppresses the toggle.
  assign fall = en & ~half_we & terminal_s & cpu_clk_r;

  assign cpu_clk = cpu_clk_r;
  assign tick    = tick_r;

  // Half-period register, phase counter, clock level and tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      half_r    <= CNT_W'(HALF_PERIOD);
      cnt_r     <= {CNT_W{1'b0}};
      cpu_clk_r <= 1'b0;
      tick_r    <= 1'b0;
    end else begin
      tick_r <= 1'b0;
      if (half_we) begin
        half_r <= clamp_half(half_in);
      end else begin
        half_r <= half_r;
      end
      if (restart) begin
        cnt_r     <= {CNT_W{1'b0}};
        cpu_clk_r <= 1'b0;
      end else if (half_we) begin
        // New length restarts the current phase; level is kept.
        cnt_r <= {CNT_W{1'b0}};
      end else if (!en) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (terminal_s) begin
        cnt_r <= {CNT_W{1'b0}};
        if (!cpu_clk_r && hold_low) begin
          // A stop is pending: do not begin another high phase.
          cpu_clk_r <= 1'b0;
        end else begin
          cpu_clk_r <= ~cpu_clk_r;
          tick_r    <= ~cpu_clk_r;
        end
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/clock_ctrl.sv
// clock_ctrl
//   Run/stop/single-step sequencer for the BasicCPU system clock. Divides
//   the board clock into a slow CPU clock, emits a one-cycle tick with
//   each CPU clock rising edge, and parks the CPU clock low whenever the
//   sequencer is halted.
//
//   Build option: define CLOCK_CTRL_AUTORUN_EN to leave reset in RUN
//   instead of HALT, so the CPU starts without a button press.
//
// Ports
//   i_clk      in   board clock
//   i_rst      in   synchronous reset, active-high
//   i_run      in   pulse: start free-running
//   i_stop     in   pulse: stop at clock-low
//   i_step     in   pulse: issue exactly one CPU clock period
//   i_halt     in   level from CPU HLT decode, acts as a held stop
//   i_half_we  in   write strobe for the half-period
//   i_half     in   new half-period value (0 is raised to 1)
//   o_cpu_clk  out  divided CPU clock, registered
//   o_tick     out  high for the cycle in which o_cpu_clk goes 0->1
//   o_running  out  sequencer is in RUN
//   o_halted   out  sequencer is in HALT
module clock_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int HALF_PERIOD = DEF_HALF_PERIOD
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_run,
  input  logic             i_stop,
  input  logic             i_step,
  input  logic             i_halt,
  input  logic             i_half_we,
  input  logic [CNT_W-1:0] i_half,
  output logic             o_cpu_clk,
  output logic             o_tick,
  output logic             o_running,
  output logic             o_halted
);

`ifdef CLOCK_CTRL_AUTORUN_EN
  localparam state_e RESET_STATE = ST_RUN;
`else
  localparam state_e RESET_STATE = ST_HALT;
`endif

  state_e state_r;
  state_e state_next_s;
  logic   stop_pend_r;
  logic   stop_pend_next_s;
  logic   stop_req_s;
  logic   en_s;
  logic   restart_s;
  logic   cpu_clk_s;
  logic   tick_s;
  logic   fall_s;

  // Any stop source, including the one arriving this cycle.
  assign stop_req_s = i_stop | i_halt | stop_pend_r;

  assign en_s = (state_r == ST_RUN) || (state_r == ST_STEP);

  // Halted, or entering/leaving HALT: the phase starts fresh and low.
  assign restart_s = (state_r == ST_HALT) || (state_next_s == ST_HALT);

  clock_phase_div #(
    .CNT_W       (CNT_W),
    .HALF_PERIOD (HALF_PERIOD)
  ) u_div (
    .clk      (i_clk),
    .rst      (i_rst),
    .en       (en_s),
    .restart  (restart_s),
    .hold_low (stop_req_s),
    .half_we  (i_half_we),
    .half_in  (i_half),
    .cpu_clk  (cpu_clk_s),
    .tick     (tick_s),
    .fall     (fall_s)
  );

  // Sequencer state and pending-stop register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r     <= RESET_STATE;
      stop_pend_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      stop_pend_r <= stop_pend_next_s;
    end
  end

  // Next-state and pending-stop decision.
  always_comb begin
    state_next_s     = state_r;
    stop_pend_next_s = stop_pend_r;
    case (state_r)
      ST_HALT: begin
        stop_pend_next_s = 1'b0;
        // Priority stop > step > run; losers are dropped.
        if (i_stop) begin
          state_next_s = ST_HALT;
        end else if (i_step) begin
          state_next_s = ST_STEP;
        end else if (i_run && !i_halt) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_HALT;
        end
      end
      ST_RUN, ST_STEP: begin
        stop_pend_next_s = stop_pend_r | i_stop | i_halt;
        if (stop_pend_r && !cpu_clk_s) begin
          // Stop already latched while low: park now.
          state_next_s     = ST_HALT;
          stop_pend_next_s = 1'b0;
        end else if (fall_s && (stop_req_s || (state_r == ST_STEP))) begin
          // The falling edge that ends the high phase also ends the run.
          state_next_s     = ST_HALT;
          stop_pend_next_s = 1'b0;
        end else begin
          state_next_s = state_r;
        end
      end
      default: begin
        state_next_s     = ST_HALT;
        stop_pend_next_s = 1'b0;
      end
    endcase
  end

  assign o_cpu_clk = cpu_clk_s;
  assign o_tick    = tick_s;
  assign o_running = (state_r == ST_RUN);
  assign o_halted  = (state_r == ST_HALT);

endmodule

// File: tb/tb_clock_ctrl.sv
// tb_clock_ctrl
//   Directed bench for clock_ctrl with a half-period of 4 board cycles.
//   "Cycle N" below is the state observed just after the N-th rising edge,
//   where edge 0 is the one that samples the command.
module tb_clock_ctrl;

  localparam int CNT_W = 24;

  logic             i_clk;
  logic             i_rst;
  logic             i_run;
  logic             i_stop;
  logic             i_step;
  logic             i_halt;
  logic             i_half_we;
  logic [CNT_W-1:0] i_half;
  logic             o_cpu_clk;
  logic             o_tick;
  logic             o_running;
  logic             o_halted;

  int vectors;
  int miscompares;
  int ticks;

  clock_ctrl #(
    .CNT_W       (CNT_W),
    .HALF_PERIOD (4)
  ) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_run     (i_run),
    .i_stop    (i_stop),
    .i_step    (i_step),
    .i_halt    (i_halt),
    .i_half_we (i_half_we),
    .i_half    (i_half),
    .o_cpu_clk (o_cpu_clk),
    .o_tick    (o_tick),
    .o_running (o_running),
    .o_halted  (o_halted)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic count_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1);
      if (o_tick) ticks++;
    end
  endtask

  task automatic pulse_run();
    i_run = 1'b1;
    cyc(1);
    i_run = 1'b0;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    cyc(1);
    i_rst = 1'b0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    i_rst = 1'b1; i_run = 1'b0; i_stop = 1'b0; i_step = 1'b0;
    i_halt = 1'b0; i_half_we = 1'b0; i_half = '0;

    // Reset values
    do_reset();
    chk("rst_halted", o_halted, 1'b1);
    chk("rst_running", o_running, 1'b0);
    chk("rst_clk", o_cpu_clk, 1'b0);
    chk("rst_tick", o_tick, 1'b0);

    // 1: free run, rises at 4 and 12, falls at 8
    pulse_run();
    chk("s1_running_c0", o_running, 1'b1);
    chk("s1_clk_c0", o_cpu_clk, 1'b0);
    for (int c = 1; c <= 12; c++) begin
      cyc(1);
      chk($sformatf("s1_clk_c%0d", c), o_cpu_clk, (c >= 4 && c < 8) || c >= 12);
      chk($sformatf("s1_tick_c%0d", c), o_tick, c == 4 || c == 12);
    end

    // 2a: stop while high at 5 -> falls and halts at 8
    do_reset();
    pulse_run();
    cyc(4);
    chk("s2a_clk_c4", o_cpu_clk, 1'b1);
    i_stop = 1'b1;
    cyc(1);
    i_stop = 1'b0;
    chk("s2a_running_c5", o_running, 1'b1);
    cyc(2);
    chk("s2a_clk_c7", o_cpu_clk, 1'b1);
    chk("s2a_running_c7", o_running, 1'b1);
    cyc(1);
    chk("s2a_clk_c8", o_cpu_clk, 1'b0);
    chk("s2a_halted_c8", o_halted, 1'b1);
    ticks = 0;
    count_ticks(10);
    chk_int("s2a_no_ticks", ticks, 0);
    chk("s2a_clk_parked", o_cpu_clk, 1'b0);

    // 2b: stop while low at 9 -> halts at 10
    pulse_run();
    cyc(8);
    chk("s2b_clk_c8", o_cpu_clk, 1'b0);
    i_stop = 1'b1;
    cyc(1);
    i_stop = 1'b0;
    chk("s2b_running_c9", o_running, 1'b1);
    cyc(1);
    chk("s2b_halted_c10", o_halted, 1'b1);
    chk("s2b_clk_c10", o_cpu_clk, 1'b0);
    ticks = 0;
    count_ticks(8);
    chk_int("s2b_no_ticks", ticks, 0);

    // 3: single step, run/step during the step are ignored
    i_step = 1'b1;
    cyc(1);
    i_step = 1'b0;
    chk("s3_halted_c0", o_halted, 1'b0);
    chk("s3_running_c0", o_running, 1'b0);
    ticks = 0;
    for (int c = 1; c <= 8; c++) begin
      if (c == 5) begin
        i_step = 1'b1;
        i_run = 1'b1;
      end
      cyc(1);
      i_step = 1'b0;
      i_run = 1'b0;
      if (o_tick) ticks++;
      if (c == 4) begin
        chk("s3_clk_c4", o_cpu_clk, 1'b1);
        chk("s3_tick_c4", o_tick, 1'b1);
      end
    end
    chk("s3_halted_c8", o_halted, 1'b1);
    chk("s3_clk_c8", o_cpu_clk, 1'b0);
    count_ticks(8);
    chk_int("s3_one_tick", ticks, 1);

    // 4: run blocked by halt level; halt in RUN stops at clock-low
    i_halt = 1'b1;
    pulse_run();
    chk("s4_blocked_halted", o_halted, 1'b1);
    chk("s4_blocked_running", o_running, 1'b0);
    cyc(3);
    chk("s4_still_halted", o_halted, 1'b1);
    i_halt = 1'b0;
    pulse_run();
    chk("s4_running_c0", o_running, 1'b1);
    cyc(4);
    chk("s4_clk_c4", o_cpu_clk, 1'b1);
    i_halt = 1'b1;
    cyc(1);
    chk("s4_running_c5", o_running, 1'b1);
    cyc(3);
    chk("s4_halted_c8", o_halted, 1'b1);
    chk("s4_clk_c8", o_cpu_clk, 1'b0);
    ticks = 0;
    count_ticks(6);
    chk_int("s4_no_ticks", ticks, 0);
    i_halt = 1'b0;

    // 5: simultaneous commands in HALT
    i_stop = 1'b1;
    i_run = 1'b1;
    cyc(1);
    i_stop = 1'b0;
    i_run = 1'b0;
    chk("s5_stoprun_halted", o_halted, 1'b1);
    chk("s5_stoprun_running", o_running, 1'b0);
    i_step = 1'b1;
    i_run = 1'b1;
    cyc(1);
    i_step = 1'b0;
    i_run = 1'b0;
    chk("s5_steprun_running", o_running, 1'b0);
    chk("s5_steprun_halted", o_halted, 1'b0);
    ticks = 0;
    count_ticks(8);
    chk("s5_halted_c8", o_halted, 1'b1);
    chk_int("s5_one_tick", ticks, 1);

    // 6: half-period writes, then reset while high
    pulse_run();
    cyc(2);
    chk("s6_clk_c2", o_cpu_clk, 1'b0);
    i_half_we = 1'b1;
    i_half = '0;
    cyc(1);
    i_half_we = 1'b0;
    chk("s6_clk_c3", o_cpu_clk, 1'b0);
    chk("s6_tick_c3", o_tick, 1'b0);
    cyc(1);
    chk("s6_clk_c4", o_cpu_clk, 1'b1);
    chk("s6_tick_c4", o_tick, 1'b1);
    cyc(1);
    chk("s6_clk_c5", o_cpu_clk, 1'b0);
    cyc(1);
    chk("s6_clk_c6", o_cpu_clk, 1'b1);
    chk("s6_tick_c6", o_tick, 1'b1);
    cyc(1);
    chk("s6_clk_c7", o_cpu_clk, 1'b0);
    // Write lands on a terminal count: no toggle, new phase of 2
    i_half_we = 1'b1;
    i_half = 24'd2;
    cyc(1);
    i_half_we = 1'b0;
    chk("s6_clk_c8", o_cpu_clk, 1'b0);
    chk("s6_tick_c8", o_tick, 1'b0);
    cyc(1);
    chk("s6_clk_c9", o_cpu_clk, 1'b0);
    cyc(1);
    chk("s6_clk_c10", o_cpu_clk, 1'b1);
    chk("s6_tick_c10", o_tick, 1'b1);
    cyc(1);
    chk("s6_clk_c11", o_cpu_clk, 1'b1);
    cyc(1);
    chk("s6_clk_c12", o_cpu_clk, 1'b0);
    cyc(2);
    chk("s6_clk_c14", o_cpu_clk, 1'b1);
    do_reset();
    chk("s6_rst_clk", o_cpu_clk, 1'b0);
    chk("s6_rst_tick", o_tick, 1'b0);
    chk("s6_rst_halted", o_halted, 1'b1);
    chk("s6_rst_running", o_running, 1'b0);
    // Half-period is back to 4 after reset
    pulse_run();
    cyc(3);
    chk("s6_post_clk_c3", o_cpu_clk, 1'b0);
    cyc(1);
    chk("s6_post_clk_c4", o_cpu_clk, 1'b1);
    chk("s6_post_tick_c4", o_tick, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/clock_ctrl.md
Name: clock_ctrl

Overview:
- Run/stop/single-step sequencer for the BasicCPU system clock.
- Divides the board clock i_clk into a slow CPU clock o_cpu_clk.
- Also produces a one-cycle o_tick enable, aligned to each CPU clock rising edge.
- Accepts debounced front-panel commands (run, stop, step) and the CPU HLT signal; always parks the CPU clock low when stopped.

Parameters:
- CNT_W, 24, width of the phase counter and of the half-period value.
- HALF_PERIOD, 130000, reset value of the half-period, in i_clk cycles (must be ≥1 and < 2^CNT_W).

Ports:
- i_clk  in  1  board clock; all logic on posedge.
- i_rst  in  1  synchronous reset, active-high.
- i_run  in  1  one-cycle pulse: start free-running.
- i_stop  in  1  one-cycle pulse: stop at clock-low.
- i_step  in  1  one-cycle pulse: issue exactly one CPU clock period.
- i_halt  in  1  level from the CPU HLT decode; stops the clock like i_stop while high.
- i_half_we  in  1  write strobe for the half-period.
- i_half  in  CNT_W  new half-period value.
- o_cpu_clk  out  1  divided CPU clock, registered.
- o_tick  out  1  high for one i_clk cycle, in the same cycle o_cpu_clk goes 0->1.
- o_running  out  1  state==RUN.
- o_halted  out  1  state==HALT.

Behaviour:
- Reset state: state=HALT, cnt=0, half=HALF_PERIOD, o_cpu_clk=0, o_tick=0, stop_pend=0, o_running=0, o_halted=1.
- States:
  - HALT: counter held at 0, o_cpu_clk=0.
  - RUN: free-running.
  - STEP: runs one full period.
- Counter and toggle (RUN and STEP only):
  - cnt increments each i_clk.
  - When cnt==half-1: cnt<=0 and o_cpu_clk toggles.
  - o_tick=1 only on the 0->1 toggle; o_tick is 0 in every other cycle.
- Timing from HALT:
  - First rising edge is registered `half` i_clk cycles after the command cycle.
  - CPU period is 2*half cycles, 50% duty.
- HALT transitions:
  - i_step -> STEP.
  - i_run with i_halt=0 -> RUN.
  - i_run with i_halt=1 is ignored.
  - Entering RUN or STEP starts a fresh phase: cnt=0, clock low.
- RUN stop handling:
  - i_stop pulse or i_halt=1 sets stop_pend.
  - If o_cpu_clk=0 when stop_pend is set or seen -> HALT next cycle, cnt<=0.
  - If o_cpu_clk=1 -> stay in RUN until the 1->0 toggle; that same edge enters HALT.
  - No extra o_tick is produced after the stop request.
- STEP:
  - After one rise (one o_tick) and the following fall -> HALT.
  - Total 2*half cycles; exactly one o_tick.
  - i_run and i_step are ignored in STEP.
  - i_stop or i_halt during STEP follows the RUN stop rule.
- Simultaneous commands in the same cycle: priority i_stop > i_step > i_run; lower-priority commands are dropped, not queued.
- i_step while in RUN is ignored.
- stop_pend clears on entry to HALT.
- Half-period write (i_half_we):
  - half<=i_half; a value of 0 is clamped to 1.
  - cnt<=0 in the same cycle; o_cpu_clk keeps its level, and the current phase restarts with the new length.
  - Legal in any state.
  - Write coincident with the terminal count: the write wins and no toggle occurs that cycle.
- half=1: o_cpu_clk toggles every i_clk (i_clk/2).
- i_rst mid-phase: immediate return to reset values next edge; o_cpu_clk drops low even if it was high.

Optional Feature:
- CLOCK_CTRL_AUTORUN_EN defined: reset state is RUN (cnt=0, clock low, o_running=1, o_halted=0), so the CPU runs out of reset with no button press. i_halt still forces HALT.
- Undefined: reset state is HALT as above.

Decomposition:
- Package clock_ctrl_pkg holds:
  - state enum (HALT, RUN, STEP);
  - default CNT_W and HALF_PERIOD constants;
  - constant for the minimum half-period (1).
- One natural sub-module, clock_phase_div: counter, half register with clamp, toggle, tick generation, with enable/restart inputs and a fall-edge indication. The FSM stays in clock_ctrl.

Test Plan:
All scenarios use HALF_PERIOD=4.
1. Reset, then i_run pulse at cycle 0 -> o_cpu_clk rises at cycle 4 with o_tick=1, falls at 8, rises at 12; o_tick high only at 4 and 12; o_running=1.
2. In RUN, i_stop while o_cpu_clk=1 (cycle 5) -> clock falls at 8 and o_halted=1 from then; no further ticks. Repeat with i_stop at cycle 9 (clock low) -> HALT at cycle 10, clock stays 0.
3. From HALT, i_step -> exactly one o_tick after 4 cycles, clock low after 8 cycles, back to HALT. i_step or i_run during the step has no effect.
4. i_halt=1, then i_run pulse -> stays HALT. i_halt=0, then i_run -> RUN. Raise i_halt in RUN -> halts at the next clock-low, as in scenario 2.
5. Same-cycle i_stop+i_run in HALT -> stays HALT. Same-cycle i_step+i_run -> STEP, single tick.
6. In RUN, write i_half=0 -> period becomes 2 cycles (clamped to 1). Write i_half=2 mid-phase -> counter restarts and the next toggle occurs 2 cycles later. Assert i_rst while o_cpu_clk=1 -> clock 0, HALT, all outputs at reset values next cycle.
